// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel clock divider with runtime-programmable divisors.
//   Each channel toggles clk_out[i] every active_div clocks (period 2*div).
//   New divisors are staged through a valid/ready port and take effect at the
//   channel's next half-period boundary, so no runt pulses are produced.
//
//   Optional feature macro: CLK_DIV_TICK_EN adds the registered 'tick' output
//   (one-cycle strobe coinciding with each clk_out toggle).
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous reset, active-high
//   en         in   per-channel run enable
//   cfg_valid  in   config request
//   cfg_ready  out  config port can accept (combinational)
//   cfg_ch     in   target channel index
//   cfg_div    in   new divisor (half-period in clk cycles, 0 treated as 1)
//   clk_out    out  divided outputs (idle/reset level 1)
//   tick       out  toggle strobe (only with CLK_DIV_TICK_EN)
module clk_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5,
    localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out
`ifdef CLK_DIV_TICK_EN
   ,output logic [CHANNELS-1:0] tick
`endif
);

    localparam logic [CHW:0] CH_LIMIT = (CHW+1)'(CHANNELS);

    logic [WIDTH-1:0]    cnt        [CHANNELS];
    logic [WIDTH-1:0]    active_div [CHANNELS];
    logic [WIDTH-1:0]    staged     [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] boundary;

    logic             cfg_in_range;
    logic             cfg_fire;
    logic [WIDTH-1:0] cfg_div_fix;

    // Out-of-range indices are always "ready" so the requester never stalls;
    // such transfers are dropped because cfg_fire also requires a valid index.
    assign cfg_in_range = ({1'b0, cfg_ch} < CH_LIMIT);
    assign cfg_ready    = cfg_in_range ? ~pending[cfg_ch] : 1'b1;
    assign cfg_fire     = cfg_valid && cfg_ready && cfg_in_range;
    assign cfg_div_fix  = (cfg_div == '0) ? WIDTH'(1) : cfg_div;

    // Compare is done in WIDTH bits so the counter wraps exactly like the register.
    always_comb begin
        boundary = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            boundary[i] = ((cnt[i] + WIDTH'(1)) == active_div[i]);
        end
    end

    // Control state: counters, output levels, active divisor, pending flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]        <= '0;
                active_div[i] <= WIDTH'(DEFAULT_DIV);
            end
            clk_out <= '1;
            pending <= '0;
`ifdef CLK_DIV_TICK_EN
            tick    <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!en[i]) begin
                    // Idle: park high, restart from zero, absorb any staged divisor.
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b1;
                    if (pending[i]) begin
                        active_div[i] <= staged[i];
                        pending[i]    <= 1'b0;
                    end
                end else if (boundary[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    if (pending[i]) begin
                        active_div[i] <= staged[i];
                        pending[i]    <= 1'b0;
                    end
                end else begin
                    cnt[i] <= cnt[i] + WIDTH'(1);
                end
                // A transfer only fires when pending[i] is clear, so it never
                // collides with the apply path above.
                if (cfg_fire && (cfg_ch == CHW'(i))) begin
                    pending[i] <= 1'b1;
                end
`ifdef CLK_DIV_TICK_EN
                tick[i] <= en[i] && boundary[i];
`endif
            end
        end
    end

    // Staged divisor is data only; pending qualifies it, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_fire && (cfg_ch == CHW'(i))) begin
                staged[i] <= cfg_div_fix;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [3:0] clk_out;

    // A 4-channel build cannot encode an out-of-range index in its 2-bit
    // cfg_ch, so a 3-channel instance covers the discard path (index 3).
    logic [2:0] en2 = '0;
    logic       cfg_valid2 = 1'b0;
    logic       cfg_ready2;
    logic [1:0] cfg_ch2 = '0;
    logic [7:0] cfg_div2 = '0;
    logic [2:0] clk_out2;
`ifdef CLK_DIV_TICK_EN
    logic [3:0] tick;
    logic [2:0] tick2;
`endif

    clk_div_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(5)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out)
`ifdef CLK_DIV_TICK_EN
       ,.tick(tick)
`endif
    );

    clk_div_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(5)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .clk_out(clk_out2)
`ifdef CLK_DIV_TICK_EN
       ,.tick(tick2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 main clk_out, 1 main cfg_ready, 2 dut2 clk_out, 3 dut2 cfg_ready, 4 main tick
    typedef struct packed {
        int         cyc;
        int         kind;
        logic [3:0] mask;
        logic [3:0] val;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    checks = 0;
    int    passed = 0;
    exp_t  e;
    string nm;
    logic [3:0] act;

    task automatic push(input int c, input int k, input logic [3:0] m,
                        input logic [3:0] v, input string n);
        q.push_back('{cyc: c, kind: k, mask: m, val: v});
        qn.push_back(n);
    endtask

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            case (e.kind)
                0:       act = clk_out;
                1:       act = {3'b000, cfg_ready};
                2:       act = {1'b0, clk_out2};
                3:       act = {3'b000, cfg_ready2};
`ifdef CLK_DIV_TICK_EN
                4:       act = tick;
`endif
                default: act = 4'hx;
            endcase
            checks++;
            if (e.cyc != cyc)
                $display("FAIL %s cyc=%0d: check was due at cyc=%0d and not taken", nm, cyc, e.cyc);
            else if ((act & e.mask) !== (e.val & e.mask))
                $display("FAIL %s cyc=%0d: got=%b want=%b mask=%b", nm, cyc, act, e.val, e.mask);
            else
                passed++;
        end
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick_clk();
    endtask

    // Level of a channel k cycles after it starts running with divisor d.
    function automatic logic lvl(input int k, input int d);
        return ((k / d) % 2) == 0;
    endfunction

    int t0, b, c, d, ee, r, f;
    logic v;

    initial begin
        // Reset state
        tick_clk();
        tick_clk();
        push(cyc, 0, 4'hF, 4'hF, "rst_clk_out");
        push(cyc, 1, 4'h1, 4'h1, "rst_cfg_ready");
        push(cyc, 2, 4'h7, 4'h7, "rst_clk_out2");
`ifdef CLK_DIV_TICK_EN
        push(cyc, 4, 4'hF, 4'h0, "rst_tick");
`endif
        tick_clk();

        // 1: default divisor on ch0 only
        t0 = cyc;
        rst = 1'b0;
        en  = 4'b0001;
        push(t0 + 1, 1, 4'h1, 4'h1, "t1_ready");
        for (int k = 1; k <= 20; k++)
            push(t0 + k, 0, 4'hF, {3'b111, lvl(k, 5)}, "t1_div5");
        wait_until(t0 + 22);

        // 2: reprogram ch0 to 2 mid half-period
        b = cyc;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        for (int k = 0; k <= 10; k++) begin
            push(b + k, 1, 4'h1, {3'b000, (k == 0 || k >= 3)}, "t2_ready");
            v = (k < 3) ? 1'b1 : (((k - 3) / 2) % 2 != 0);
            push(b + k, 0, 4'hF, {3'b111, v}, "t2_reprog");
        end
        wait_until(b + 1);
        cfg_valid = 1'b0;
        wait_until(b + 11);

        // 3: cfg_div=0 to idle ch1, then enable -> period 2
        c = cyc;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        for (int k = 0; k <= 12; k++) begin
            if (k <= 2) push(c + k, 1, 4'h1, {3'b000, (k != 1)}, "t3_ready");
            v = (k < 3) ? 1'b1 : (k % 2 == 0);
            push(c + k, 0, 4'hE, {2'b11, v, 1'b0}, "t3_div0");
        end
        wait_until(c + 1);
        cfg_valid = 1'b0;
        wait_until(c + 2);
        en = 4'b0011;
        wait_until(c + 16);

        // 5: drop en[0] right after a fall, re-enable 3 clks later
        d = cyc;
        en = 4'b0010;
        push(d, 0, 4'h1, 4'h0, "t5_before");
        for (int k = 1; k <= 8; k++) begin
            v = (k <= 4) ? 1'b1 : (k >= 7);
            push(d + k, 0, 4'h1, {3'b000, v}, "t5_reenable");
        end
        wait_until(d + 3);
        en = 4'b0011;
        wait_until(d + 10);

        // 6: reset mid-run with ch2 pending
        ee = cyc;
        en = 4'b0111;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        push(ee + 1, 1, 4'h1, 4'h0, "t6_pending");
        push(ee + 2, 0, 4'hF, 4'hF, "t6_rst_clk_out");
        push(ee + 2, 1, 4'h1, 4'h1, "t6_rst_ready");
        push(ee + 3, 0, 4'hF, 4'hF, "t6_rst_hold");
`ifdef CLK_DIV_TICK_EN
        push(ee + 3, 4, 4'hF, 4'h0, "t6_rst_tick");
`endif
        wait_until(ee + 1);
        cfg_valid = 1'b0;
        wait_until(ee + 2);
        rst = 1'b1;
        wait_until(ee + 3);
        r = cyc;
        rst = 1'b0;
        en2 = 3'b111;
        push(r + 1, 1, 4'h1, 4'h1, "t6_ready_after");
        for (int k = 1; k <= 20; k++) begin
            v = lvl(k, 5);
            push(r + k, 0, 4'hF, {1'b1, v, v, v}, "t6_default");
            push(r + k, 2, 4'h7, {1'b0, v, v, v}, "t6_default2");
`ifdef CLK_DIV_TICK_EN
            push(r + k, 4, 4'hF, {1'b0, {3{(k % 5 == 0)}}}, "t6_tick");
`endif
        end
        wait_until(r + 20);

        // 4: out-of-range channel on the 3-channel instance
        f = cyc;
        cfg_valid2 = 1'b1; cfg_ch2 = 2'd3; cfg_div2 = 8'd1;
        for (int k = 20; k <= 70; k++) begin
            if (k <= 22) push(r + k, 3, 4'h1, 4'h1, "t4_ready");
            v = lvl(k, 5);
            push(r + k, 2, 4'h7, {1'b0, v, v, v}, "t4_unchanged");
        end
        wait_until(f + 2);
        cfg_valid2 = 1'b0;
        wait_until(r + 71);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick_clk();
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d checks left unconsumed, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
